// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the up/down counter and its checker.
// Functions operate on a fixed maximum width; callers zero-extend narrower
// values and truncate the result, which is exact because zero upper bits
// contribute nothing to either transform.
package gray_pkg;

  localparam int GRAY_MAX_W = 32;

  // Counter limit behaviour selected by the SATURATE parameter.
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down: each binary bit is the parity of all
  // Gray bits at or above it.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter.
// Ports:
//   gray  in   WIDTH  Gray-coded value
//   bin   out  WIDTH  binary equivalent
module gray2bin_conv #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each bit is the parity of the Gray bits from the MSB down to itself;
  // written as independent reductions so there is no ripple chain through
  // a single vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_updown_counter.sv
// Synchronous up/down Gray-code counter with load, wrap/saturate mode and
// status flags. The binary count is the state; the Gray code is registered
// alongside it so both outputs change on the same edge and the Gray output
// is glitch-free for downstream pointer/CDC logic.
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous active-high reset
//   up         in   1      count-up request (level, sampled on clk)
//   down       in   1      count-down request (level, sampled on clk)
//   load       in   1      synchronous load of load_code (highest priority)
//   load_code  in   WIDTH  Gray-coded load value
//   code       out  WIDTH  registered Gray code of the count
//   bin        out  WIDTH  registered binary count
//   wrap       out  1      one-cycle pulse after a wrapping step (wrap mode only)
//   at_max     out  1      count is 2**WIDTH-1
//   at_min     out  1      count is 0
module gray_updown_counter
  import gray_pkg::*;
#(
  parameter int          WIDTH     = 3,
  parameter int          SATURATE  = 0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_code,
  output logic [WIDTH-1:0] code,
  output logic [WIDTH-1:0] bin,
  output logic             wrap,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] BIN_MAX  = '1;
  localparam logic [WIDTH-1:0] BIN_MIN  = '0;
  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RST_CODE = RST_BIN ^ (RST_BIN >> 1);
  localparam bit               SAT_MODE = (SATURATE == MODE_SAT);

  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin_nxt;
  logic             wrap_nxt;

  gray2bin_conv #(
    .WIDTH(WIDTH)
  ) u_load_conv (
    .gray(load_code),
    .bin (load_bin)
  );

  // Next-count selection: load > single-direction step > hold.
  // load_code only reaches the state through the load branch, so an
  // undriven load_code cannot disturb the count while load is low.
  always_comb begin
    bin_nxt  = bin;
    wrap_nxt = 1'b0;
    if (load) begin
      bin_nxt = load_bin;
    end else if (up ^ down) begin
      if (up) begin
        if (bin == BIN_MAX) begin
          if (!SAT_MODE) begin
            bin_nxt  = BIN_MIN;
            wrap_nxt = 1'b1;
          end
        end else begin
          bin_nxt = bin + 1'b1;
        end
      end else begin
        if (bin == BIN_MIN) begin
          if (!SAT_MODE) begin
            bin_nxt  = BIN_MAX;
            wrap_nxt = 1'b1;
          end
        end else begin
          bin_nxt = bin - 1'b1;
        end
      end
    end
  end

  // ---- stage boundary: count, Gray code and wrap pulse registered together ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin  <= RST_BIN;
      code <= RST_CODE;
      wrap <= 1'b0;
    end else begin
      bin  <= bin_nxt;
      code <= WIDTH'(bin2gray(GRAY_MAX_W'(bin_nxt)));
      wrap <= wrap_nxt;
    end
  end

  // Flags decode registered state only.
  assign at_max = (bin == BIN_MAX);
  assign at_min = (bin == BIN_MIN);

endmodule

// File: tb/tb_gray_updown_counter.sv
module tb_gray_updown_counter;

  localparam int W = 3;

  typedef struct {
    logic [W-1:0] code;
    logic [W-1:0] bin;
    logic         wrap;
    logic         amax;
    logic         amin;
    logic         cstep;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         up, down, load;
  logic [W-1:0] load_code;

  logic [W-1:0] code0, bin0, code1, bin1, chk_bin0;
  logic         wrap0, amax0, amin0, wrap1, amax1, amin1;

  int total = 0;
  int bad   = 0;

  exp_t q[$];
  int   mb[2];
  logic [W-1:0] prev_code[2];
  const bit is_sat[2] = '{1'b0, 1'b1};

  always #5 clk = ~clk;

  gray_updown_counter #(.WIDTH(W), .SATURATE(0), .RESET_VAL(0)) dut_w (
    .clk(clk), .reset(reset), .up(up), .down(down), .load(load),
    .load_code(load_code), .code(code0), .bin(bin0), .wrap(wrap0),
    .at_max(amax0), .at_min(amin0)
  );

  gray_updown_counter #(.WIDTH(W), .SATURATE(1), .RESET_VAL(0)) dut_s (
    .clk(clk), .reset(reset), .up(up), .down(down), .load(load),
    .load_code(load_code), .code(code1), .bin(bin1), .wrap(wrap1),
    .at_max(amax1), .at_min(amin1)
  );

  // Converter reused as a consistency checker on the wrap-mode outputs.
  gray2bin_conv #(.WIDTH(W)) u_chk (.gray(code0), .bin(chk_bin0));

  function automatic logic [W-1:0] tb_g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    for (int i = 0; i < W; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  function automatic logic [W-1:0] tb_b2g(input int b);
    logic [W-1:0] v;
    v = W'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int k, input exp_t e, input string tag);
    logic [W-1:0] c, b;
    logic         wr, mx, mn;
    c  = (k == 0) ? code0 : code1;
    b  = (k == 0) ? bin0  : bin1;
    wr = (k == 0) ? wrap0 : wrap1;
    mx = (k == 0) ? amax0 : amax1;
    mn = (k == 0) ? amin0 : amin1;
    chk($sformatf("%s/d%0d/code", tag, k), 32'(c), 32'(e.code));
    chk($sformatf("%s/d%0d/bin", tag, k), 32'(b), 32'(e.bin));
    chk($sformatf("%s/d%0d/wrap", tag, k), 32'(wr), 32'(e.wrap));
    chk($sformatf("%s/d%0d/at_max", tag, k), 32'(mx), 32'(e.amax));
    chk($sformatf("%s/d%0d/at_min", tag, k), 32'(mn), 32'(e.amin));
    if (e.cstep)
      chk($sformatf("%s/d%0d/onebit", tag, k), 32'($countones(c ^ prev_code[k])), 32'd1);
    prev_code[k] = c;
  endtask

  // Drive one clock's worth of inputs, push the model's prediction for each
  // counter, then pop and compare after the edge.
  task automatic step(input logic u, input logic d, input logic l,
                      input logic [W-1:0] lc, input string tag);
    exp_t e;
    int   nb;
    logic nw;
    @(negedge clk);
    up = u; down = d; load = l; load_code = lc;
    for (int k = 0; k < 2; k++) begin
      nb = mb[k];
      nw = 1'b0;
      if (l) nb = int'(tb_g2b(lc));
      else if (u && !d) begin
        if (mb[k] == 7) begin
          if (!is_sat[k]) begin nb = 0; nw = 1'b1; end
        end else nb = mb[k] + 1;
      end else if (d && !u) begin
        if (mb[k] == 0) begin
          if (!is_sat[k]) begin nb = 7; nw = 1'b1; end
        end else nb = mb[k] - 1;
      end
      e.cstep = !l && (nb != mb[k]);
      e.bin   = W'(nb);
      e.code  = tb_b2g(nb);
      e.wrap  = nw;
      e.amax  = (nb == 7);
      e.amin  = (nb == 0);
      q.push_back(e);
      mb[k] = nb;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (q.size() == 0) begin
        chk({tag, "/queue_empty"}, 32'd0, 32'd1);
      end else begin
        e = q.pop_front();
        check_dut(k, e, tag);
      end
    end
    chk({tag, "/conv"}, 32'(chk_bin0), 32'(bin0));
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s/d%0d/code", tag, k), 32'((k == 0) ? code0 : code1), 32'd0);
      chk($sformatf("%s/d%0d/bin", tag, k), 32'((k == 0) ? bin0 : bin1), 32'd0);
      chk($sformatf("%s/d%0d/wrap", tag, k), 32'((k == 0) ? wrap0 : wrap1), 32'd0);
      chk($sformatf("%s/d%0d/at_min", tag, k), 32'((k == 0) ? amin0 : amin1), 32'd1);
      mb[k] = 0;
      prev_code[k] = '0;
    end
  endtask

  initial begin
    logic [W-1:0] gtbl [8];
    gtbl = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    reset = 1'b1; up = 1'b0; down = 1'b0; load = 1'b0; load_code = 'x;
    #1;
    check_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1: count up through the whole Gray sequence
    for (int i = 1; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0, 'x, $sformatf("t1_up%0d", i));
      chk($sformatf("t1_tbl%0d", i), 32'(code0), 32'(gtbl[i]));
    end

    // 2: wrap from max, pulse lasts one cycle; saturating copy holds
    step(1'b1, 1'b0, 1'b0, 'x, "t2_wrap");
    step(1'b1, 1'b0, 1'b0, '0, "t2_up2");
    step(1'b0, 1'b0, 1'b0, '0, "t2_idle");

    // 3: from 000 (load to be sure), down wraps to 100, next down to 101
    step(1'b0, 1'b0, 1'b1, 3'b000, "t3_load");
    step(1'b0, 1'b1, 1'b0, '0, "t3_dn1");
    step(1'b0, 1'b1, 1'b0, '0, "t3_dn2");

    // 4: up and down together hold at 011
    step(1'b0, 1'b0, 1'b1, 3'b011, "t4_load");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0, $sformatf("t4_both%0d", i));

    // 5: load beats up
    step(1'b1, 1'b0, 1'b1, 3'b110, "t5_load_up");

    // 6: saturating copy holds at max over two ups
    step(1'b0, 1'b0, 1'b1, 3'b100, "t6_load");
    step(1'b1, 1'b0, 1'b0, '0, "t6_up1");
    step(1'b1, 1'b0, 1'b0, '0, "t6_up2");

    // Randomised mix of steps
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] lc;
      lc = W'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), lc, $sformatf("rnd%0d", i));
    end

    // 6 cont.: reset mid-cycle takes effect before the next edge
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_reset_state("t6_async_rst");
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b0, '0, "t6_after_rst");
    step(1'b0, 1'b1, 1'b0, '0, "t6_after_rst_dn");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
